ble_cmd_framer: RTL and testbench
=================================

# ble_cmd_framer

Byte-to-command framer between the BLE UART transceiver and the KnightsTour command processor. It assembles pairs of received bytes, high byte first, into 16-bit commands and offers them to the command processor through a ready/clear handshake. It also queues response bytes, such as 8'hA5 (complete) and 8'h5A (intermediate), for transmission back over the UART. Any partial command whose second byte does not arrive in time is discarded.

## Interface
- TIMEOUT_CYCLES, 1_000_000: maximum clk cycles allowed between the high and low byte of one command.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_rdy  in  1  UART RX holds a byte; deasserts the cycle after clr_rx_rdy
- rx_data  in  8  received byte, valid while rx_rdy
- clr_rx_rdy  out  1  combinational one-cycle consume strobe to UART RX
- cmd  out  16  assembled command {high, low}
- cmd_rdy  out  1  cmd valid, held until cleared
- clr_cmd_rdy  in  1  command processor consumed cmd
- frame_err  out  1  one-cycle pulse: partial command dropped on timeout
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle request to send resp
- tx_data  out  8  byte to UART TX
- trmt  out  1  one-cycle start strobe to UART TX
- tx_done  in  1  one-cycle pulse: UART TX finished byte
- resp_sent  out  1  one-cycle pulse per completed response
- resp_ovf  out  1  one-cycle pulse: response dropped, queue full

## Operation
- RX FSM states: IDLE, HIGH, FULL. Reset → IDLE, cmd=16'h0000, timer=0.
- IDLE: clr_rx_rdy = rx_rdy. On consume, latch rx_data into cmd[15:8] and go to HIGH. Timer clears.
- HIGH: clr_rx_rdy = rx_rdy. On consume, latch cmd[7:0] and go to FULL. Otherwise the timer increments. When timer reaches TIMEOUT_CYCLES-1 with no byte, pulse frame_err and go to IDLE. cmd[15:8] keeps its stale value, but cmd_rdy stays 0. A byte and the timeout in the same cycle: the byte wins.
- FULL: cmd_rdy=1 and clr_rx_rdy=0, so RX is back-pressured and the byte stays pending in the UART. On clr_cmd_rdy go to IDLE. A pending byte is consumed no earlier than the following cycle.
- TX FSM states: TX_IDLE, TX_BUSY, plus a 1-entry pending register with a valid bit.
- TX_IDLE + send_resp: tx_data←resp, trmt pulses next cycle, go to TX_BUSY.
- TX_BUSY + send_resp, pending empty: store resp in pending. If pending is full: drop resp and pulse resp_ovf.
- TX_BUSY + tx_done: pulse resp_sent. If pending is valid, load it into tx_data, pulse trmt, clear pending, and stay in TX_BUSY. Otherwise go to TX_IDLE.
- tx_done + send_resp in the same cycle:
  - pending empty: send the new resp directly.
  - pending full: launch the pending byte and store the new resp in pending. No overflow.
- Reset mid-operation returns both FSMs to their reset state immediately. Any partial command, cmd_rdy, and pending response are lost.
- Reset values of all outputs: clr_rx_rdy=0, cmd=0, cmd_rdy=0, frame_err=0, tx_data=0, trmt=0, resp_sent=0, resp_ovf=0.

## Timing
- Low byte consumed at edge N → cmd_rdy=1 and cmd valid after edge N.
- clr_cmd_rdy sampled at edge M → cmd_rdy=0 after edge M.
- send_resp sampled at edge N in TX_IDLE → trmt high for cycle N+1 only.
- tx_done with a valid pending entry at edge N → trmt high for cycle N+1, and resp_sent also in cycle N+1.
- Timeout: frame_err fires exactly TIMEOUT_CYCLES cycles after the high byte is consumed, if no low byte arrives.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer saturates and does not wrap.

## Structure
- tb_package-adjacent shared package holds:
  - rx_state_t and tx_state_t enums
  - COMM_COMPLETE=8'hA5 and COMM_INTERMEDIATE=8'h5A
  - opcode field constants cmd[15:12]: 4'b0000 calibrate, 4'b0010 move, 4'b0011 move with fanfare, 4'b0100 tour
- Sub-module ble_resp_queue holds the TX FSM, the pending register and the overflow logic. The top level keeps the RX FSM and the timer.

## Test plan
- Bytes 8'h40, 8'h22 back-to-back → one cmd_rdy with cmd=16'h4022. clr_cmd_rdy drops cmd_rdy next cycle. frame_err never fires.
- TIMEOUT_CYCLES=100. Byte 8'h2B, then silence → frame_err at cycle 100, no cmd_rdy. Then 8'h20, 8'h03 → cmd=16'h2003.
- cmd_rdy held for 50 cycles with rx_rdy high → clr_rx_rdy stays 0 throughout. Byte consumed the cycle after clr_cmd_rdy.
- send_resp 8'h5A, then 8'hA5 while busy, then 8'h11 while busy → trmt with 5A, resp_ovf on 8'h11. After tx_done, trmt with A5. Two resp_sent pulses in total.
- tx_done and send_resp 8'hA5 in the same cycle, pending full with 8'h5A → 5A launched, A5 queued, no resp_ovf.
- rst asserted in HIGH state and while TX_BUSY → all outputs 0 immediately. Next byte pair assembles correctly.

Source files
------------

// File: rtl/ble_cmd_framer_pkg.sv
// Shared types and constants for the BLE command framer and its response queue.
package ble_cmd_framer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        FULL
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam logic [7:0] COMM_COMPLETE     = 8'hA5;
    localparam logic [7:0] COMM_INTERMEDIATE = 8'h5A;

    // Opcode lives in cmd[15:12]
    localparam logic [3:0] OP_CALIBRATE    = 4'b0000;
    localparam logic [3:0] OP_MOVE         = 4'b0010;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;
    localparam logic [3:0] OP_TOUR         = 4'b0100;

    function automatic logic [3:0] cmd_opcode(input logic [15:0] cmd);
        return cmd[15:12];
    endfunction

endpackage

// File: rtl/ble_cmd_framer_resp_queue.sv
// Response transmit path: one byte in flight at the UART plus one pending byte.
module ble_resp_queue
    import ble_cmd_framer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_resp,
    input  logic       i_send_resp,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_data,
    output logic       o_trmt,
    output logic       o_resp_sent,
    output logic       o_resp_ovf
);

    tx_state_t  r_state;
    logic [7:0] r_pend;
    logic       r_pend_vld;
    logic [7:0] r_tx_data;
    logic       r_trmt;
    logic       r_resp_sent;
    logic       r_resp_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= TX_IDLE;
            r_pend      <= 8'h00;
            r_pend_vld  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
            r_resp_ovf  <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_resp_sent <= 1'b0;
            r_resp_ovf  <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (i_send_resp) begin
                        r_tx_data <= i_resp;
                        r_trmt    <= 1'b1;
                        r_state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (i_tx_done) begin
                        r_resp_sent <= 1'b1;
                        if (r_pend_vld) begin
                            // A simultaneous request refills the slot just freed
                            r_tx_data <= r_pend;
                            r_trmt    <= 1'b1;
                            if (i_send_resp) r_pend <= i_resp;
                            else             r_pend_vld <= 1'b0;
                        end else if (i_send_resp) begin
                            r_tx_data <= i_resp;
                            r_trmt    <= 1'b1;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else if (i_send_resp) begin
                        if (!r_pend_vld) begin
                            r_pend     <= i_resp;
                            r_pend_vld <= 1'b1;
                        end else begin
                            r_resp_ovf <= 1'b1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_trmt      = r_trmt;
    assign o_resp_sent = r_resp_sent;
    assign o_resp_ovf  = r_resp_ovf;

endmodule

// File: rtl/ble_cmd_framer.sv
// Assembles UART byte pairs into 16-bit commands and queues response bytes back to the UART.
module ble_cmd_framer
    import ble_cmd_framer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_rdy,
    input  logic [7:0]  i_rx_data,
    output logic        o_clr_rx_rdy,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    output logic        o_frame_err,
    input  logic [7:0]  i_resp,
    input  logic        i_send_resp,
    output logic [7:0]  o_tx_data,
    output logic        o_trmt,
    input  logic        i_tx_done,
    output logic        o_resp_sent,
    output logic        o_resp_ovf
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    rx_state_t   r_state;
    logic [TW-1:0] r_timer;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        r_frame_err;
    logic        w_take;

    // FULL back-pressures the UART; the byte stays pending there
    assign w_take       = i_rx_rdy && (r_state != FULL) && !i_rst;
    assign o_clr_rx_rdy = w_take;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_cmd       <= 16'h0000;
            r_cmd_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_take) begin
                        r_cmd[15:8] <= i_rx_data;
                        r_state     <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_take) begin
                        r_cmd[7:0] <= i_rx_data;
                        r_cmd_rdy  <= 1'b1;
                        r_state    <= FULL;
                    end else if (r_timer == TLAST) begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                FULL: begin
                    if (i_clr_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmd       = r_cmd;
    assign o_cmd_rdy   = r_cmd_rdy;
    assign o_frame_err = r_frame_err;

    ble_resp_queue u_resp_queue (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_resp      (i_resp),
        .i_send_resp (i_send_resp),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_trmt      (o_trmt),
        .o_resp_sent (o_resp_sent),
        .o_resp_ovf  (o_resp_ovf)
    );

endmodule

// File: tb/tb_ble_cmd_framer.sv
// Self-checking bench: vector table, directed corner sequences, random traffic vs a queue model.
module tb_ble_cmd_framer;
    import ble_cmd_framer_pkg::*;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_done = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frame_err;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        resp_sent;
    logic        resp_ovf;

    ble_cmd_framer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_rdy(rx_rdy), .i_rx_data(rx_data), .o_clr_rx_rdy(clr_rx_rdy),
        .o_cmd(cmd), .o_cmd_rdy(cmd_rdy), .i_clr_cmd_rdy(clr_cmd_rdy),
        .o_frame_err(frame_err),
        .i_resp(resp), .i_send_resp(send_resp),
        .o_tx_data(tx_data), .o_trmt(trmt), .i_tx_done(tx_done),
        .o_resp_sent(resp_sent), .o_resp_ovf(resp_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int sent_cnt = 0;
    logic [7:0] rx_q[$];
    logic s_clr = 1'b0;
    logic consumed = 1'b0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
        logic [3:0]  exp_op;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // UART RX model: byte held until the cycle after it was consumed
    task automatic refresh_rx();
        rx_rdy = (rx_q.size() != 0);
        if (rx_rdy) rx_data = rx_q[0];
        else        rx_data = 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        refresh_rx();
    endtask

    // One clock: ends 3 time units after the rising edge with one-shot inputs cleared
    task automatic step();
        #1;
        s_clr = clr_rx_rdy;
        @(posedge clk);
        #1;
        consumed = s_clr;
        if (s_clr && rx_q.size() != 0) void'(rx_q.pop_front());
        refresh_rx();
        send_resp = 1'b0;
        tx_done = 1'b0;
        clr_cmd_rdy = 1'b0;
        #2;
        if (frame_err) fe_cnt++;
        if (resp_sent) sent_cnt++;
    endtask

    task automatic wait_cmd(input string nm, output int n);
        n = 0;
        while (!cmd_rdy && n < 300) begin
            step();
            n++;
        end
        chk({nm, " cmd_rdy seen"}, 32'(cmd_rdy), 32'd1);
    endtask

    task automatic send(input logic [7:0] r);
        resp = r;
        send_resp = 1'b1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " clr_rx_rdy"}, 32'(clr_rx_rdy), 32'd0);
        chk({nm, " cmd"},        32'(cmd),        32'd0);
        chk({nm, " cmd_rdy"},    32'(cmd_rdy),    32'd0);
        chk({nm, " frame_err"},  32'(frame_err),  32'd0);
        chk({nm, " tx_data"},    32'(tx_data),    32'd0);
        chk({nm, " trmt"},       32'(trmt),       32'd0);
        chk({nm, " resp_sent"},  32'(resp_sent),  32'd0);
        chk({nm, " resp_ovf"},   32'(resp_ovf),   32'd0);
    endtask

    initial begin
        int n;
        int k;
        int ones;
        bit rdy_seen;

        vt[0] = '{8'h40, 8'h22, 16'h4022, OP_TOUR};
        vt[1] = '{8'h20, 8'h03, 16'h2003, OP_MOVE};
        vt[2] = '{8'h00, 8'h00, 16'h0000, OP_CALIBRATE};
        vt[3] = '{8'h35, 8'hA7, 16'h35A7, OP_MOVE_FANFARE};
        vt[4] = '{8'hFF, 8'h01, 16'hFF01, 4'hF};

        // reset state, including clr_rx_rdy gated while a byte is offered
        rx_rdy = 1'b1;
        rx_data = 8'hEE;
        #3;
        chk_all_zero("reset");
        rx_rdy = 1'b0;
        rx_data = 8'h00;
        step();
        step();
        rst = 1'b0;
        step();

        // vector table: back-to-back byte pairs
        fe_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            push(vt[i].hi);
            push(vt[i].lo);
            wait_cmd("vec", n);
            chk("vec latency", 32'(n), 32'd2);
            chk("vec cmd", 32'(cmd), 32'(vt[i].exp_cmd));
            chk("vec opcode", 32'(cmd_opcode(cmd)), 32'(vt[i].exp_op));
            step();
            chk("vec cmd_rdy held", 32'(cmd_rdy), 32'd1);
            clr_cmd_rdy = 1'b1;
            step();
            chk("vec cmd_rdy cleared", 32'(cmd_rdy), 32'd0);
        end
        chk("vec no frame_err", 32'(fe_cnt), 32'd0);

        // timeout after a lone high byte
        push(8'h2B);
        k = -1;
        rdy_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (consumed) k = 0;
            else if (k >= 0) k++;
            if (cmd_rdy) rdy_seen = 1'b1;
            if (frame_err) break;
        end
        chk("timeout frame_err", 32'(frame_err), 32'd1);
        chk("timeout latency", 32'(k), 32'(TO));
        chk("timeout no cmd_rdy", 32'(rdy_seen), 32'd0);
        step();
        chk("timeout pulse width", 32'(frame_err), 32'd0);
        push(8'h20);
        push(8'h03);
        wait_cmd("post-timeout", n);
        chk("post-timeout cmd", 32'(cmd), 32'h2003);
        clr_cmd_rdy = 1'b1;
        step();

        // back-pressure while cmd_rdy is held
        push(8'h41); push(8'h11); push(8'h42); push(8'h22);
        wait_cmd("bp", n);
        chk("bp cmd", 32'(cmd), 32'h4111);
        ones = 0;
        for (int c = 0; c < 50; c++) begin
            if (clr_rx_rdy) ones++;
            step();
        end
        chk("bp clr_rx_rdy held low", 32'(ones), 32'd0);
        chk("bp rx_rdy pending", 32'(rx_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        step();
        chk("bp no consume on clr edge", 32'(consumed), 32'd0);
        chk("bp cmd_rdy dropped", 32'(cmd_rdy), 32'd0);
        chk("bp clr_rx_rdy after clear", 32'(clr_rx_rdy), 32'd1);
        step();
        chk("bp consumed next cycle", 32'(consumed), 32'd1);
        wait_cmd("bp2", n);
        chk("bp second cmd", 32'(cmd), 32'h4222);
        clr_cmd_rdy = 1'b1;
        step();

        // responses: one in flight, one pending, third overflows
        sent_cnt = 0;
        send(COMM_INTERMEDIATE);
        step();
        chk("tx first trmt", 32'(trmt), 32'd1);
        chk("tx first data", 32'(tx_data), 32'h5A);
        send(COMM_COMPLETE);
        step();
        chk("tx queued no trmt", 32'(trmt), 32'd0);
        chk("tx queued no ovf", 32'(resp_ovf), 32'd0);
        send(8'h11);
        step();
        chk("tx ovf", 32'(resp_ovf), 32'd1);
        step();
        chk("tx ovf pulse", 32'(resp_ovf), 32'd0);
        tx_done = 1'b1;
        step();
        chk("tx pend trmt", 32'(trmt), 32'd1);
        chk("tx pend data", 32'(tx_data), 32'hA5);
        chk("tx pend sent", 32'(resp_sent), 32'd1);
        step();
        chk("tx trmt pulse", 32'(trmt), 32'd0);
        tx_done = 1'b1;
        step();
        chk("tx last no trmt", 32'(trmt), 32'd0);
        chk("tx sent total", 32'(sent_cnt), 32'd2);

        // tx_done and send_resp together, pending full
        send(8'h11); step();
        send(COMM_INTERMEDIATE); step();
        tx_done = 1'b1;
        send(COMM_COMPLETE);
        step();
        chk("same full trmt", 32'(trmt), 32'd1);
        chk("same full data", 32'(tx_data), 32'h5A);
        chk("same full no ovf", 32'(resp_ovf), 32'd0);
        tx_done = 1'b1; step();
        chk("same full next data", 32'(tx_data), 32'hA5);
        chk("same full next trmt", 32'(trmt), 32'd1);
        tx_done = 1'b1; step();

        // tx_done and send_resp together, pending empty
        send(8'h11); step();
        tx_done = 1'b1;
        send(8'h22);
        step();
        chk("same empty trmt", 32'(trmt), 32'd1);
        chk("same empty data", 32'(tx_data), 32'h22);
        tx_done = 1'b1; step();
        chk("same empty idle", 32'(trmt), 32'd0);

        // reset mid-frame and mid-transmit
        push(8'h33);
        step();
        send(8'h5A); step();
        send(8'h66); step();
        push(8'h44);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        rx_q.delete();
        refresh_rx();
        step();
        rst = 1'b0;
        step();
        push(8'h40);
        push(8'h01);
        wait_cmd("post-reset", n);
        chk("post-reset latency", 32'(n), 32'd2);
        chk("post-reset cmd", 32'(cmd), 32'h4001);
        clr_cmd_rdy = 1'b1;
        tx_done = 1'b1;
        step();
        chk("post-reset pending lost", 32'(trmt), 32'd0);
        send(8'h77); step();
        chk("post-reset tx data", 32'(tx_data), 32'h77);
        tx_done = 1'b1; step();

        // random traffic against a FIFO/occupancy model
        begin
            logic [15:0] exp_cmd_q[$];
            logic [7:0]  exp_tx[$];
            int  occ = 0;
            bit  ubusy = 1'b0;
            int  ucnt = 0;
            bit  prev_rdy = 1'b0;
            bit  exp_ovf;
            bit  exp_done;
            bit  exp_trmt;
            logic [7:0] hi, lo;
            fe_cnt = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c < 2800 && rx_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                    hi = 8'($urandom);
                    lo = 8'($urandom);
                    push(hi);
                    push(lo);
                    exp_cmd_q.push_back({hi, lo});
                end
                clr_cmd_rdy = cmd_rdy && ($urandom_range(0, 2) == 0);
                if (ubusy) begin
                    if (ucnt == 0) begin
                        tx_done = 1'b1;
                        ubusy = 1'b0;
                    end else ucnt--;
                end
                exp_done = tx_done;
                if (c < 2800 && $urandom_range(0, 2) == 0) send(8'($urandom));
                exp_ovf = 1'b0;
                if (tx_done) occ--;
                if (send_resp) begin
                    if (occ < 2) begin
                        occ++;
                        exp_tx.push_back(resp);
                    end else exp_ovf = 1'b1;
                end
                if (cmd_rdy) chk("rand backpressure", 32'(clr_rx_rdy), 32'd0);
                step();
                chk("rand resp_ovf", 32'(resp_ovf), 32'(exp_ovf));
                chk("rand resp_sent", 32'(resp_sent), 32'(exp_done));
                exp_trmt = !ubusy && (exp_tx.size() != 0);
                chk("rand trmt", 32'(trmt), 32'(exp_trmt));
                if (trmt && exp_tx.size() != 0) begin
                    chk("rand tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                    ubusy = 1'b1;
                    ucnt = $urandom_range(0, 4);
                end
                if (cmd_rdy && !prev_rdy) begin
                    if (exp_cmd_q.size() == 0) chk("rand unexpected cmd", 32'(cmd), 32'hFFFF_FFFF);
                    else chk("rand cmd", 32'(cmd), 32'(exp_cmd_q.pop_front()));
                end
                prev_rdy = cmd_rdy;
            end
            chk("rand cmds drained", 32'(exp_cmd_q.size()), 32'd0);
            chk("rand tx drained", 32'(exp_tx.size()), 32'd0);
            chk("rand no frame_err", 32'(fe_cnt), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
